// File: rtl/aes_pkg.sv
// Shared AES constants and types for the byte-serial InvSubBytes engine.
package aes_pkg;

   localparam int unsigned AES_STATE_W   = 128;
   localparam int unsigned AES_BYTE_W    = 8;
   localparam int unsigned AES_NUM_BYTES = 16;
   localparam int unsigned AES_IDX_W     = $clog2(AES_NUM_BYTES);

   typedef logic [AES_IDX_W-1:0] aes_byte_idx_t;

   // Slot AES_NUM_BYTES-1 holds byte 0 ([127:120]); slot 0 holds byte 15 ([7:0]).
   typedef logic [AES_NUM_BYTES-1:0][AES_BYTE_W-1:0] aes_state_t;

   localparam aes_byte_idx_t AES_LAST_IDX = AES_IDX_W'(AES_NUM_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } inv_sb_state_t;

   // Packed slot holding AES byte number idx.
   function automatic aes_byte_idx_t byte_slot(input aes_byte_idx_t idx);
      return AES_IDX_W'(AES_LAST_IDX - idx);
   endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box (FIPS-197 Fig. 14), 8-bit in, 8-bit out.
module inv_sbox
   import aes_pkg::*;
(
   input  logic [AES_BYTE_W-1:0] in_byte,
   output logic [AES_BYTE_W-1:0] out_byte
);

   // Row r of the table covers input bytes 8'hr0..8'hrf.
   localparam logic [0:255][AES_BYTE_W-1:0] INV_SBOX_LUT = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   assign out_byte = INV_SBOX_LUT[in_byte];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Byte-serial AES InvSubBytes engine: one shared inv_sbox, one byte per clock.
// Define AES_INV_SBOX_REG_EN to register the S-box output before write-back.
module inv_sub_bytes_seq
   import aes_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_state,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_state,
   output logic                   busy
);

   inv_sb_state_t   fsm_q, fsm_d;
   aes_byte_idx_t   idx_q, idx_d;
   aes_state_t      data_q, data_d;
   logic [AES_BYTE_W-1:0] sbox_in, sbox_out;

   assign sbox_in = data_q[byte_slot(idx_q)];

   inv_sbox u_inv_sbox (
      .in_byte  (sbox_in),
      .out_byte (sbox_out)
   );

`ifdef AES_INV_SBOX_REG_EN
   logic                  pipe_vld_q, pipe_vld_d;
   aes_byte_idx_t         pipe_idx_q, pipe_idx_d;
   logic [AES_BYTE_W-1:0] pipe_byte_q, pipe_byte_d;
   logic                  issue_done_q, issue_done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld_q   <= 1'b0;
         pipe_idx_q   <= '0;
         pipe_byte_q  <= '0;
         issue_done_q <= 1'b0;
      end else begin
         pipe_vld_q   <= pipe_vld_d;
         pipe_idx_q   <= pipe_idx_d;
         pipe_byte_q  <= pipe_byte_d;
         issue_done_q <= issue_done_d;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q  <= IDLE;
         idx_q  <= '0;
         data_q <= '0;
      end else begin
         fsm_q  <= fsm_d;
         idx_q  <= idx_d;
         data_q <= data_d;
      end
   end

   // Next-state, byte index and state-register write-back.
   always_comb begin
      fsm_d  = fsm_q;
      idx_d  = idx_q;
      data_d = data_q;
`ifdef AES_INV_SBOX_REG_EN
      pipe_vld_d   = 1'b0;
      pipe_idx_d   = pipe_idx_q;
      pipe_byte_d  = pipe_byte_q;
      issue_done_d = issue_done_q;
`endif
      unique case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               data_d = aes_state_t'(in_state);
               idx_d  = '0;
               fsm_d  = RUN;
`ifdef AES_INV_SBOX_REG_EN
               issue_done_d = 1'b0;
`endif
            end
         end
         RUN: begin
`ifdef AES_INV_SBOX_REG_EN
            // Lookup issue runs one cycle ahead of the write-back.
            if (!issue_done_q) begin
               pipe_vld_d  = 1'b1;
               pipe_idx_d  = idx_q;
               pipe_byte_d = sbox_out;
               idx_d       = AES_IDX_W'(idx_q + 1'b1);
               if (idx_q == AES_LAST_IDX) begin
                  issue_done_d = 1'b1;
               end
            end
            if (pipe_vld_q) begin
               data_d[byte_slot(pipe_idx_q)] = pipe_byte_q;
               if (pipe_idx_q == AES_LAST_IDX) begin
                  fsm_d = DONE;
               end
            end
`else
            data_d[byte_slot(idx_q)] = sbox_out;
            idx_d = AES_IDX_W'(idx_q + 1'b1);
            if (idx_q == AES_LAST_IDX) begin
               fsm_d = DONE;
            end
`endif
         end
         DONE: begin
            if (out_ready) begin
               fsm_d = IDLE;
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (fsm_q == IDLE);
   assign busy      = (fsm_q == RUN);
   assign out_valid = (fsm_q == DONE);
   assign out_state = AES_STATE_W'(data_q);

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboard bench for inv_sub_bytes_seq against an arithmetic GF(2^8) model.
module tb_inv_sub_bytes_seq;

`ifdef AES_INV_SBOX_REG_EN
   localparam int RUN_CYC = 17;
`else
   localparam int RUN_CYC = 16;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   inv_sub_bytes_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int ready_mode = 1;   // 0 = hold low, 1 = high, 2 = random
   int n_loads  = 0;
   int n_results = 0;
   logic ov_prev = 1'b0;

   logic [127:0] exp_q[$];
   int           acc_q[$];
   int           res_cyc[$];

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
   endtask

   // ---------------- reference model: GF(2^8) arithmetic ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      logic [7:0] p = a;
      if (a == 8'h00) return 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (((254 >> i) & 1) == 1) r = gmul(r, p);
         p = gmul(p, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   function automatic logic [7:0] inv_sbox_ref(input logic [7:0] b);
      return ginv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] y = ginv(x);
      return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] inv_sub_bytes_ref(input logic [127:0] s);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = inv_sbox_ref(s[127 - 8*k -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- downstream ready driver ----------------
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst) begin
         ov_prev = 1'b0;
      end else begin
         if (out_valid && !ov_prev) begin
            if (acc_q.size() == 0) chk("spurious_result", 128'(out_valid), 128'(0));
            else chk("latency", 128'(cyc - acc_q.pop_front()), 128'(RUN_CYC + 1));
         end
         if (out_valid) begin
            chk("in_ready_in_done", 128'(in_ready), 128'(0));
            chk("busy_in_done", 128'(busy), 128'(0));
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 128'(out_valid), 128'(0));
            end else if (out_ready) begin
               chk("result", out_state, exp_q.pop_front());
               res_cyc.push_back(cyc);
               n_results++;
            end else begin
               chk("hold_stable", out_state, exp_q[0]);
            end
         end
         ov_prev = out_valid;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load(input logic [127:0] st, input logic [127:0] exp);
      int w = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_state = st;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 128'(in_ready), 128'(1));
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(exp);
      acc_q.push_back(cyc);
      n_loads++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_state = rand128();
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 500) begin
         @(posedge clk);
         w++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'(0));
   endtask

   task automatic wait_out_valid();
      int w = 0;
      while (!out_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!out_valid) chk("out_valid_timeout", 128'(out_valid), 128'(1));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [127:0] st, orig;
      int gap;

      rst = 1'b1;
      in_valid = 1'b0;
      in_state = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 128'(in_ready), 128'(1));
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_out_state", out_state, 128'h0);
      rst = 1'b0;

      // directed vectors
      ready_mode = 1;
      st = {16{8'h63}};
      load(st, inv_sub_bytes_ref(st));
      drain();
      st = 128'h3d06ca2cdb0000000000000000000016;
      load(st, inv_sub_bytes_ref(st));
      drain();

      // backpressure plus ignored in_valid pulses during RUN and DONE
      ready_mode = 0;
      @(posedge clk); #1;
      st = rand128();
      load(st, inv_sub_bytes_ref(st));
      repeat (3) @(posedge clk);
      #1;
      chk("busy_in_run", 128'(busy), 128'(1));
      in_valid = 1'b1; in_state = rand128();
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out_valid();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = (i % 3 == 0);
         in_state = rand128();
      end
      in_valid = 1'b0;
      ready_mode = 1;
      drain();
      repeat (40) @(posedge clk);

      // asynchronous reset with byte index at 7
      st = rand128();
      load(st, inv_sub_bytes_ref(st));
      repeat (7) @(posedge clk);
      #2;
      chk("busy_before_reset", 128'(busy), 128'(1));
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 128'(out_valid), 128'(0));
      chk("midrst_in_ready", 128'(in_ready), 128'(1));
      chk("midrst_out_state", out_state, 128'h0);
      chk("midrst_busy", 128'(busy), 128'(0));
      exp_q.delete();
      acc_q.delete();
      n_loads--;
      @(posedge clk); #1;
      rst = 1'b0;
      st = {16{8'h7c}};
      load(st, inv_sub_bytes_ref(st));
      drain();

      // back-to-back spacing with out_ready tied high
      res_cyc.delete();
      st = rand128();
      load(st, inv_sub_bytes_ref(st));
      st = rand128();
      load(st, inv_sub_bytes_ref(st));
      drain();
      if (res_cyc.size() == 2) chk("b2b_spacing", 128'(res_cyc[1] - res_cyc[0]), 128'(RUN_CYC + 2));
      else chk("b2b_result_count", 128'(res_cyc.size()), 128'(2));

      // round-trip: forward S-box outputs must map back to the originals
      ready_mode = 2;
      for (int t = 0; t < 20; t++) begin
         orig = rand128();
         for (int k = 0; k < 16; k++) st[127 - 8*k -: 8] = sbox_ref(orig[127 - 8*k -: 8]);
         load(st, orig);
         gap = $urandom_range(0, 3);
         repeat (gap) @(posedge clk);
      end
      drain();
      ready_mode = 1;
      repeat (30) @(posedge clk);

      chk("result_count", 128'(n_results), 128'(n_loads));
      chk("leftover_expected", 128'(exp_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
